// File: rtl/x_tp_mem_pkg.sv
// Shared helpers for the two-port register-file memory and its FIFO controller.
package x_tp_mem_pkg;

  // Address width used by both the memory and the FIFO pointers; a single-entry
  // array still gets a 1-bit address so port widths never collapse to zero.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/x_tp_mem.sv
// Two-port register-file memory: one synchronous write port, one combinational
// read port. Storage array behind the FIFO controller; reads have zero latency so
// data is valid in the same cycle the controller's empty flag drops.
module x_tp_mem
  import x_tp_mem_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               we,
  input  logic [addr_width(DEPTH)-1:0]       waddr,
  input  logic [addr_width(DEPTH)-1:0]       raddr,
  input  logic [DW-1:0]                      d,
  output logic [DW-1:0]                      q
);

  localparam int unsigned AW = addr_width(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] wen;

  // Per-entry write decode; addresses >= DEPTH match no entry and are dropped.
  always_comb begin
    wen = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wen[i] = we && (waddr == AW'(i));
    end
  end

  // Entry storage: async clear, then at most one entry updated per edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        // Mux form so an X enable propagates X into the addressed entry only.
        mem_q[i] <= wen[i] ? d : mem_q[i];
      end
    end
  end

  // Combinational read; out-of-range addresses read as zero. No write bypass.
  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        q = mem_q[i];
      end
    end
  end

endmodule

// File: tb/tb_x_tp_mem.sv
// Directed bench for x_tp_mem: DEPTH 4 main instance plus DEPTH 3 and DEPTH 1
// instances for out-of-range and degenerate-size behaviour.
module tb_x_tp_mem;

  logic clk;
  logic rstn;

  // DEPTH = 4 (AW = 2)
  logic       we4;
  logic [1:0] waddr4, raddr4;
  logic [7:0] d4, q4;
  // DEPTH = 3 (AW = 2)
  logic       we3;
  logic [1:0] waddr3, raddr3;
  logic [7:0] d3, q3;
  // DEPTH = 1 (AW = 1)
  logic       we1;
  logic [0:0] waddr1, raddr1;
  logic [7:0] d1, q1;

  int n_cmp;
  int n_err;

  x_tp_mem #(.DW(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .we(we4), .waddr(waddr4), .raddr(raddr4), .d(d4), .q(q4)
  );
  x_tp_mem #(.DW(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .we(we3), .waddr(waddr3), .raddr(raddr3), .d(d3), .q(q3)
  );
  x_tp_mem #(.DW(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .we(we1), .waddr(waddr1), .raddr(raddr1), .d(d1), .q(q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [7:0] exp;
    rstn = 1'b0;
    we4 = 1'b1;
    d4 = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      waddr4 = 2'(c);
    end
    for (int a = 0; a < 4; a++) begin
      raddr4 = 2'(a);
      #1;
      exp = 8'h00;
      n_cmp++;
      if (q4 !== exp) begin
        n_err++;
        $display("FAIL reset_hold addr %0d: got %h expected %h", a, q4, exp);
      end
    end
    @(negedge clk);
    we4 = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      raddr4 = 2'(a);
      #1;
      exp = 8'h00;
      n_cmp++;
      if (q4 !== exp) begin
        n_err++;
        $display("FAIL reset_release addr %0d: got %h expected %h", a, q4, exp);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      we4 = 1'b1;
      waddr4 = 2'(a);
      d4 = 8'hA0 + 8'(a);
    end
    @(negedge clk);
    we4 = 1'b0;
    // Sweep with no clock edge between address change and check.
    for (int a = 0; a < 4; a++) begin
      raddr4 = 2'(a);
      #1;
      exp = 8'hA0 + 8'(a);
      n_cmp++;
      if (q4 !== exp) begin
        n_err++;
        $display("FAIL fill_readback addr %0d: got %h expected %h", a, q4, exp);
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp;
    @(negedge clk);
    we4 = 1'b1;
    waddr4 = 2'd2;
    d4 = 8'h55;
    @(negedge clk);
    waddr4 = 2'd2;
    raddr4 = 2'd2;
    d4 = 8'hC3;
    #1;
    exp = 8'h55;
    n_cmp++;
    if (q4 !== exp) begin
      n_err++;
      $display("FAIL collision_before: got %h expected %h", q4, exp);
    end
    @(posedge clk);
    #1;
    exp = 8'hC3;
    n_cmp++;
    if (q4 !== exp) begin
      n_err++;
      $display("FAIL collision_after: got %h expected %h", q4, exp);
    end
    @(negedge clk);
    we4 = 1'b0;
  endtask

  task automatic test_we_gating();
    logic [7:0] exp_tbl [4];
    exp_tbl[0] = 8'hA0;
    exp_tbl[1] = 8'hA1;
    exp_tbl[2] = 8'hC3;
    exp_tbl[3] = 8'hA3;
    @(negedge clk);
    we4 = 1'b0;
    waddr4 = 2'd1;
    d4 = 8'hEE;
    repeat (5) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      raddr4 = 2'(a);
      #1;
      n_cmp++;
      if (q4 !== exp_tbl[a]) begin
        n_err++;
        $display("FAIL we_gating addr %0d: got %h expected %h", a, q4, exp_tbl[a]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    @(negedge clk);
    raddr4 = 2'd3;
    #1;
    exp = 8'hA3;
    n_cmp++;
    if (q4 !== exp) begin
      n_err++;
      $display("FAIL async_pre: got %h expected %h", q4, exp);
    end
    // Assert reset mid-cycle, well before the next rising edge.
    #1;
    rstn = 1'b0;
    #1;
    exp = 8'h00;
    n_cmp++;
    if (q4 !== exp) begin
      n_err++;
      $display("FAIL async_drop: got %h expected %h", q4, exp);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      raddr4 = 2'(a);
      #1;
      exp = 8'h00;
      n_cmp++;
      if (q4 !== exp) begin
        n_err++;
        $display("FAIL async_after addr %0d: got %h expected %h", a, q4, exp);
      end
    end
  endtask

  task automatic test_small_depths();
    logic [7:0] exp;
    // DEPTH 3: write addr 2 (legal) then addr 3 (dropped)
    @(negedge clk);
    we3 = 1'b1;
    waddr3 = 2'd2;
    d3 = 8'h11;
    we1 = 1'b1;
    waddr1 = 1'b0;
    d1 = 8'h5A;
    @(negedge clk);
    waddr3 = 2'd3;
    d3 = 8'h77;
    waddr1 = 1'b1;
    d1 = 8'h99;
    @(negedge clk);
    we3 = 1'b0;
    we1 = 1'b0;
    raddr3 = 2'd3;
    #1;
    exp = 8'h00;
    n_cmp++;
    if (q3 !== exp) begin
      n_err++;
      $display("FAIL depth3_oor_read: got %h expected %h", q3, exp);
    end
    raddr3 = 2'd2;
    #1;
    exp = 8'h11;
    n_cmp++;
    if (q3 !== exp) begin
      n_err++;
      $display("FAIL depth3_addr2: got %h expected %h", q3, exp);
    end
    raddr3 = 2'd0;
    #1;
    exp = 8'h00;
    n_cmp++;
    if (q3 !== exp) begin
      n_err++;
      $display("FAIL depth3_addr0: got %h expected %h", q3, exp);
    end
    raddr1 = 1'b0;
    #1;
    exp = 8'h5A;
    n_cmp++;
    if (q1 !== exp) begin
      n_err++;
      $display("FAIL depth1_addr0: got %h expected %h", q1, exp);
    end
    raddr1 = 1'b1;
    #1;
    exp = 8'h00;
    n_cmp++;
    if (q1 !== exp) begin
      n_err++;
      $display("FAIL depth1_oor_read: got %h expected %h", q1, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    we4 = 1'b0; waddr4 = '0; raddr4 = '0; d4 = '0;
    we3 = 1'b0; waddr3 = '0; raddr3 = '0; d3 = '0;
    we1 = 1'b0; waddr1 = '0; raddr1 = '0; d1 = '0;
    test_reset();
    test_fill();
    test_collision();
    test_we_gating();
    test_async_reset();
    test_small_depths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
